// File: rtl/peak_hold_8.sv
// Streaming 8-bit peak detector placed downstream of an external magnitude comparator.
// The running maximum drives the comparator reference operand. The comparator's active-low
// "not equal" and "not greater" flags steer the maximum, first-occurrence index and tie
// count over a frame of FRAME_LEN valid samples. The result is published with a DONE pulse.
module peak_hold_8 #(
  parameter int unsigned FRAME_LEN = 16,
  parameter int unsigned IDX_W     = 4
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             start_i,
  input  logic [7:0]       din_i,
  input  logic             din_vld_i,
  input  logic             cmp_ne_i,
  input  logic             cmp_ngt_i,
  output logic [7:0]       ref_o,
  output logic [7:0]       peak_o,
  output logic [IDX_W-1:0] peak_idx_o,
  output logic [IDX_W-1:0] tie_cnt_o,
  output logic             busy_o,
  output logic             done_o,
  output logic             prot_err_o
);

  // One extra bit so the counter can hold FRAME_LEN itself when FRAME_LEN == 2**IDX_W.
  localparam int unsigned CntW = IDX_W + 1;
  localparam logic [CntW-1:0]  LastCnt = CntW'(FRAME_LEN - 1);
  localparam logic [IDX_W-1:0] TieMax  = {IDX_W{1'b1}};

  typedef enum logic [1:0] {
    StIdle,
    StFirst,
    StRun,
    StFin
  } state_e;

  state_e           state_q;
  logic [7:0]       ref_q;
  logic [7:0]       peak_q;
  logic [IDX_W-1:0] peak_idx_q;
  logic [IDX_W-1:0] tie_cnt_q;
  logic [IDX_W-1:0] widx_q;
  logic [IDX_W-1:0] wtie_q;
  logic [CntW-1:0]  cnt_q;
  logic             busy_q;
  logic             done_q;
  logic             prot_err_q;

  logic             greater;
  logic             equal;
  logic             bad_flags;
  logic             last_smp;
  logic [7:0]       ref_d;
  logic [IDX_W-1:0] widx_d;
  logic [IDX_W-1:0] wtie_d;

  // Decode the comparator flags into the working-register update for one RUN sample.
  always_comb begin
    greater   = ~cmp_ngt_i;
    equal     = ~cmp_ne_i;
    // Both flags low is impossible for a healthy comparator; it is resolved as "greater".
    bad_flags = greater & equal;
    last_smp  = (cnt_q == LastCnt);
    ref_d     = ref_q;
    widx_d    = widx_q;
    wtie_d    = wtie_q;
    if (greater) begin
      ref_d  = din_i;
      widx_d = cnt_q[IDX_W-1:0];
      wtie_d = '0;
    end else if (equal && (wtie_q != TieMax)) begin
      wtie_d = wtie_q + 1'b1;
    end
  end

  // Frame sequencer; every output is a register so DONE/BUSY/PEAK change on the same edge.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= StIdle;
      ref_q      <= '0;
      peak_q     <= '0;
      peak_idx_q <= '0;
      tie_cnt_q  <= '0;
      widx_q     <= '0;
      wtie_q     <= '0;
      cnt_q      <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      prot_err_q <= 1'b0;
    end else begin
      done_q <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (start_i) begin
            state_q    <= StFirst;
            busy_q     <= 1'b1;
            prot_err_q <= 1'b0;
            widx_q     <= '0;
            wtie_q     <= '0;
          end
        end
        StFirst: begin
          // First sample seeds the maximum; the comparator flags are meaningless here.
          if (din_vld_i) begin
            ref_q   <= din_i;
            widx_q  <= '0;
            wtie_q  <= '0;
            cnt_q   <= CntW'(1);
            state_q <= StRun;
          end
        end
        StRun: begin
          if (din_vld_i) begin
            ref_q  <= ref_d;
            widx_q <= widx_d;
            wtie_q <= wtie_d;
            cnt_q  <= cnt_q + 1'b1;
            if (bad_flags) begin
              prot_err_q <= 1'b1;
            end
            if (last_smp) begin
              // Publish from the post-update values so the last sample is included.
              state_q    <= StFin;
              done_q     <= 1'b1;
              busy_q     <= 1'b0;
              peak_q     <= ref_d;
              peak_idx_q <= widx_d;
              tie_cnt_q  <= wtie_d;
            end
          end
        end
        StFin: begin
          state_q <= StIdle;
        end
        default: begin
          state_q <= StIdle;
        end
      endcase
    end
  end

  assign ref_o      = ref_q;
  assign peak_o     = peak_q;
  assign peak_idx_o = peak_idx_q;
  assign tie_cnt_o  = tie_cnt_q;
  assign busy_o     = busy_q;
  assign done_o     = done_q;
  assign prot_err_o = prot_err_q;

endmodule
